// File: rtl/cube_digit_serial.sv
// Digit-serial integer cuber: produces x^3 and x^2 one operand bit per cycle, MSB first,
// using shift-add recurrences for the running root, square and cube partials.
module cube_digit_serial #(
  parameter int unsigned WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     x_in,
  output logic                 busy,
  output logic                 done,
  output logic [3*WIDTH-1:0]   cube,
  output logic [2*WIDTH-1:0]   square
);

  localparam int unsigned CW   = 3 * WIDTH;
  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  x_q, x_d;
  logic [CW-1:0]     y_q, y_d;
  logic [CW-1:0]     s_q, s_d;
  logic [CW-1:0]     c_q, c_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CW-1:0]     cube_q, cube_d;
  logic [2*WIDTH-1:0] square_q, square_d;

  logic          b;
  logic [CW-1:0] y_step, s_step, c_step;

  // One recurrence step; the b-gated increments replace any multiplier.
  always_comb begin
    b      = x_q[idx_q];
    y_step = (y_q << 1) + CW'(b);
    s_step = (s_q << 2);
    c_step = (c_q << 3);
    if (b) begin
      s_step = s_step + (y_q << 2) + CW'(1);
      c_step = c_step + (s_q << 3) + (s_q << 2) + (y_q << 2) + (y_q << 1) + CW'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    s_d      = s_q;
    c_d      = c_q;
    idx_d    = idx_q;
    cube_d   = cube_q;
    square_d = square_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          x_d     = x_in;
          y_d     = '0;
          s_d     = '0;
          c_d     = '0;
          idx_d   = LastIdx;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        y_d = y_step;
        s_d = s_step;
        c_d = c_step;
        if (idx_q == '0) begin
          state_d  = StDone;
          cube_d   = c_step;
          square_d = s_step[2*WIDTH-1:0];
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      s_q      <= '0;
      c_q      <= '0;
      idx_q    <= '0;
      cube_q   <= '0;
      square_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      s_q      <= s_d;
      c_q      <= c_d;
      idx_q    <= idx_d;
      cube_q   <= cube_d;
      square_q <= square_d;
    end
  end

  assign busy   = (state_q == StRun);
  assign done   = (state_q == StDone);
  assign cube   = cube_q;
  assign square = square_q;

endmodule

// File: tb/tb_cube_digit_serial.sv
// Directed bench for cube_digit_serial: latency, pulse shape, back-to-back, abort and a sweep.
module tb_cube_digit_serial;

  localparam int unsigned WIDTH = 12;

  logic               clk;
  logic               reset;
  logic               start;
  logic [WIDTH-1:0]   x_in;
  logic               busy;
  logic               done;
  logic [3*WIDTH-1:0] cube;
  logic [2*WIDTH-1:0] square;

  int checks;
  int failures;

  cube_digit_serial #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .x_in   (x_in),
    .busy   (busy),
    .done   (done),
    .cube   (cube),
    .square (square)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives start for the next edge only.
  task automatic start_op(input logic [WIDTH-1:0] x);
    x_in  = x;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Called right after the accepting edge; edges counts from that edge to done.
  task automatic wait_done(output int edges, output int busy_cycles);
    edges       = 1;
    busy_cycles = 0;
    while (done !== 1'b1 && edges < 40) begin
      if (busy === 1'b1) busy_cycles++;
      step();
      edges++;
    end
  endtask

  task automatic run_one(input string tag, input logic [WIDTH-1:0] x,
                         input logic [63:0] exp_cube, input logic [63:0] exp_sq);
    int edges;
    int bc;
    start_op(x);
    wait_done(edges, bc);
    check({tag, "_latency"}, 64'(edges), 64'd13);
    check({tag, "_cube"}, 64'(cube), exp_cube);
    check({tag, "_square"}, 64'(square), exp_sq);
  endtask

  initial begin
    int edges;
    int bc;
    int sweep_bad;
    logic [63:0] xv;
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    start     = 1'b0;
    x_in      = '0;
    step();
    step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_cube", 64'(cube), 64'd0);
    check("rst_square", 64'(square), 64'd0);
    reset = 1'b0;
    step();

    // x = 0
    run_one("zero", 12'd0, 64'd0, 64'd0);
    step();

    // x = 5 with busy/done shape
    start_op(12'd5);
    wait_done(edges, bc);
    check("five_latency", 64'(edges), 64'd13);
    check("five_busy_cycles", 64'(bc), 64'd12);
    check("five_busy_in_done", 64'(busy), 64'd0);
    check("five_cube", 64'(cube), 64'd125);
    check("five_square", 64'(square), 64'd25);
    step();
    check("five_done_pulse", 64'(done), 64'd0);
    check("five_hold_cube", 64'(cube), 64'd125);

    // all-ones operand
    run_one("max", 12'd4095, 64'd68669157375, 64'd16769025);
    step();
    run_one("x1625", 12'd1625, 64'd4291015625, 64'd2640625);
    step();

    // back-to-back with start held, x_in toggled mid-run
    x_in  = 12'd3;
    start = 1'b1;
    step();
    x_in = 12'd7;
    check("b2b_hold_prev", 64'(cube), 64'd4291015625);
    wait_done(edges, bc);
    check("b2b0_latency", 64'(edges), 64'd13);
    check("b2b0_cube", 64'(cube), 64'd27);
    check("b2b0_square", 64'(square), 64'd9);
    step();
    start = 1'b0;
    x_in  = 12'd9;
    check("b2b1_busy", 64'(busy), 64'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    x_in  = 12'd11;
    wait_done(edges, bc);
    check("b2b1_latency", 64'(edges), 64'd12);
    check("b2b1_cube", 64'(cube), 64'd343);
    check("b2b1_square", 64'(square), 64'd49);
    step();

    // abort mid-run
    start_op(12'd100);
    repeat (5) step();
    check("abort_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_cube", 64'(cube), 64'd0);
    check("abort_square", 64'(square), 64'd0);
    step();
    reset = 1'b0;
    edges = 0;
    repeat (16) begin
      step();
      if (done === 1'b1 || busy === 1'b1) edges++;
    end
    check("abort_no_activity", 64'(edges), 64'd0);
    run_one("x100", 12'd100, 64'd1000000, 64'd10000);
    step();

    // sweep 0..1625 against the bench's own product
    sweep_bad = 0;
    for (int x = 0; x <= 1625; x++) begin
      xv = 64'(x);
      start_op(12'(x));
      wait_done(edges, bc);
      if (edges != 13 || 64'(cube) !== xv * xv * xv || 64'(square) !== xv * xv) begin
        if (sweep_bad < 4)
          $display("sweep x=%0d cube=%0d square=%0d edges=%0d", x, cube, square, edges);
        sweep_bad++;
      end
    end
    check("sweep_errors", 64'(sweep_bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
